// File: rtl/sha1_pkg.sv
// Shared SHA-1 types and constants for the round driver, its digest FIFO and the round core.
package sha1_pkg;

  localparam int unsigned WORD_W          = 32;
  localparam int unsigned ROUNDS          = 80;
  localparam int unsigned WORDS_PER_BLOCK = 16;
  localparam int unsigned ROUND_W         = 7;

  typedef logic [WORD_W-1:0]  word_t;
  typedef logic [ROUND_W-1:0] round_t;

  // 160-bit digest, h0 in the most significant word
  typedef struct packed {
    word_t h0;
    word_t h1;
    word_t h2;
    word_t h3;
    word_t h4;
  } digest_t;

  typedef enum logic [2:0] {
    ST_FLUSH_CHK,
    ST_FLUSH_PULSE,
    ST_FLUSH_W1,
    ST_FLUSH_W2,
    ST_IDLE,
    ST_RUN
  } state_t;

  localparam word_t H0_INIT = 32'h6745_2301;
  localparam word_t H1_INIT = 32'hefcd_ab89;
  localparam word_t H2_INIT = 32'h98ba_dcfe;
  localparam word_t H3_INIT = 32'h1032_5476;
  localparam word_t H4_INIT = 32'hc3d2_e1f0;

  localparam word_t K0 = 32'h5a82_7999;
  localparam word_t K1 = 32'h6ed9_eba1;
  localparam word_t K2 = 32'h8f1b_bcdc;
  localparam word_t K3 = 32'hca62_c1d6;

  function automatic word_t rol30(input word_t x);
    return {x[1:0], x[31:2]};
  endfunction

endpackage

// File: rtl/sha1_digest_fifo.sv
// Small valid/ready FIFO of finished digests; push has no back-pressure because
// the issuer only starts a block when a slot is guaranteed.
module sha1_digest_fifo
  import sha1_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  digest_t                      push_data,
  output digest_t                      pop_data,
  output logic                         pop_valid,
  input  logic                         pop_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  digest_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             pop;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + PTR_W'(1);
  endfunction

  assign pop       = pop_valid && pop_ready;
  assign pop_valid = (count != '0);
  assign pop_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // On a full FIFO a same-cycle push lands in the slot being popped
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/sha1_round_driver.sv
// Buffers 16-word blocks, steps the single-round SHA-1 core through 80 rounds
// and rebuilds the digest from the last five A values it returns.
module sha1_round_driver
  import sha1_pkg::*;
#(
  parameter int unsigned CORE_LATENCY = 6,
  parameter int unsigned DIGEST_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  word_in,
  input  logic         word_valid,
  output logic         word_ready,
  output logic [31:0]  core_din,
  output logic         core_load,
  output logic         core_phase_advance,
  input  logic [31:0]  core_a,
  input  logic [1:0]   core_phase,
  output logic [159:0] digest,
  output logic         digest_valid,
  input  logic         digest_ready
);

  localparam int unsigned CNT_W = $clog2(WORDS_PER_BLOCK + 1);
  localparam int unsigned PTR_W = $clog2(WORDS_PER_BLOCK);
  localparam int unsigned OCC_W = $clog2(DIGEST_DEPTH + 1);

  state_t           state, state_n;
  round_t           rnd;
  word_t            buf_mem [WORDS_PER_BLOCK];
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [OCC_W-1:0] inflight;
  logic [OCC_W-1:0] fifo_count;
  logic             tag_vld [CORE_LATENCY];
  round_t           tag_rnd [CORE_LATENCY];
  word_t            a75, a76, a77, a78;
  logic             word_acc, running, issue_free, start, push, flushing;
  logic             cap_vld;
  round_t           cap_rnd;
  digest_t          fin, fifo_data;
  logic             fifo_valid;

  assign running    = (state == ST_RUN);
  assign flushing   = (state == ST_FLUSH_CHK) || (state == ST_FLUSH_PULSE) ||
                      (state == ST_FLUSH_W1)  || (state == ST_FLUSH_W2);
  assign word_acc   = word_valid && word_ready;
  assign issue_free = running && (rnd < round_t'(WORDS_PER_BLOCK));
  assign start      = (count == CNT_W'(WORDS_PER_BLOCK)) &&
                      ((32'(inflight) + 32'(fifo_count)) < DIGEST_DEPTH) &&
                      ((state == ST_IDLE) || (running && rnd == round_t'(ROUNDS - 1)));

  always_ff @(posedge clk) begin
    if (rst) state <= ST_FLUSH_CHK;
    else     state <= state_n;
  end

  // Core phase has no reset: pulse phase_advance until it reads 3
  always_comb begin
    state_n = state;
    unique case (state)
      ST_FLUSH_CHK:   state_n = (core_phase == 2'd3) ? ST_IDLE : ST_FLUSH_PULSE;
      ST_FLUSH_PULSE: state_n = ST_FLUSH_W1;
      ST_FLUSH_W1:    state_n = ST_FLUSH_W2;
      ST_FLUSH_W2:    state_n = ST_FLUSH_CHK;
      ST_IDLE:        if (start) state_n = ST_RUN;
      ST_RUN:         if (rnd == round_t'(ROUNDS - 1)) state_n = start ? ST_RUN : ST_IDLE;
      default:        state_n = ST_FLUSH_CHK;
    endcase
  end

  always_comb begin
    word_ready         = 1'b0;
    core_load          = 1'b0;
    core_din           = '0;
    core_phase_advance = 1'b0;
    if (!rst) begin
      word_ready         = (count < CNT_W'(WORDS_PER_BLOCK)) && !flushing;
      core_load          = issue_free;
      core_din           = issue_free ? buf_mem[rnd[PTR_W-1:0]] : '0;
      core_phase_advance = (state == ST_FLUSH_PULSE) ||
                           (running && (rnd == 7'd0 || rnd == 7'd20 ||
                                        rnd == 7'd40 || rnd == 7'd60));
    end
  end

  // Slot r is released on its issue cycle, so the next block fills behind the reader
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_mem <= '{default: '0};
      wr_ptr  <= '0;
      count   <= '0;
    end else begin
      if (word_acc) begin
        buf_mem[wr_ptr] <= word_in;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(word_acc) - CNT_W'(issue_free);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rnd      <= '0;
      inflight <= '0;
    end else begin
      if (start || (running && rnd == round_t'(ROUNDS - 1))) rnd <= '0;
      else if (running)                                       rnd <= rnd + round_t'(1);
      inflight <= inflight + OCC_W'(start) - OCC_W'(push);
    end
  end

  // Tag pipe lines up each issued round with its A value coming back from the core
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld <= '{default: 1'b0};
      tag_rnd <= '{default: '0};
    end else begin
      tag_vld[0] <= running;
      tag_rnd[0] <= rnd;
      for (int i = 1; i < CORE_LATENCY; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_rnd[i] <= tag_rnd[i-1];
      end
    end
  end

  assign cap_vld = tag_vld[CORE_LATENCY-1];
  assign cap_rnd = tag_rnd[CORE_LATENCY-1];
  assign push    = cap_vld && (cap_rnd == round_t'(ROUNDS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      a75 <= '0;
      a76 <= '0;
      a77 <= '0;
      a78 <= '0;
    end else if (cap_vld) begin
      if (cap_rnd == 7'd75) a75 <= core_a;
      if (cap_rnd == 7'd76) a76 <= core_a;
      if (cap_rnd == 7'd77) a77 <= core_a;
      if (cap_rnd == 7'd78) a78 <= core_a;
    end
  end

  // Final e,d,c are A values rotated by 30; a79 is taken straight off the core
  always_comb begin
    fin.h0 = H0_INIT + core_a;
    fin.h1 = H1_INIT + a78;
    fin.h2 = H2_INIT + rol30(a77);
    fin.h3 = H3_INIT + rol30(a76);
    fin.h4 = H4_INIT + rol30(a75);
  end

  sha1_digest_fifo #(
    .DEPTH (DIGEST_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (fin),
    .pop_data  (fifo_data),
    .pop_valid (fifo_valid),
    .pop_ready (digest_ready),
    .count     (fifo_count)
  );

  assign digest_valid = !rst && fifo_valid;
  assign digest       = digest_valid ? 160'(fifo_data) : '0;

endmodule
